// File: rtl/alu_mdu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_control
// Brief    : EX-stage ALU operation decoder with an iterative multiply/divide
//            unit, HI/LO registers, MFHI/MFLO readback and a stall interlock.
// Revision : 1.0
// ============================================================================
module alu_mdu_control #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
    input  logic [5:0]              alu_function_i,
    input  logic [DATA_WIDTH-1:0]   rs_data_i,
    input  logic [DATA_WIDTH-1:0]   rt_data_i,
    output logic [3:0]              alu_operation_o,
    output logic                    mdu_sel_o,
    output logic [DATA_WIDTH-1:0]   mdu_result_o,
    output logic                    stall_o,
    output logic                    busy_o,
    output logic [DATA_WIDTH-1:0]   hi_o,
    output logic [DATA_WIDTH-1:0]   lo_o
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_WIDTH - 1);

    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_rtype = ALU_OP_WIDTH'(3'b111);
    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_andi  = ALU_OP_WIDTH'(3'b010);
    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_addi  = ALU_OP_WIDTH'(3'b100);
    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_lui   = ALU_OP_WIDTH'(3'b000);
    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_ori   = ALU_OP_WIDTH'(3'b001);
    localparam logic [ALU_OP_WIDTH-1:0] c_aluop_lw    = ALU_OP_WIDTH'(3'b011);

    localparam logic [5:0] c_fn_mfhi = 6'b010000;
    localparam logic [5:0] c_fn_mflo = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_a;      // product high half / partial remainder
    logic [DATA_WIDTH-1:0] r_b;      // multiplier / dividend-then-quotient
    logic [DATA_WIDTH-1:0] r_m;      // multiplicand / divisor
    logic                  r_is_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div_zero;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;

    logic                  w_rtype;
    logic                  w_mdu_op;
    logic                  w_mf_op;
    logic                  w_rs_neg;
    logic                  w_rt_neg;
    logic [DATA_WIDTH-1:0] w_abs_rs;
    logic [DATA_WIDTH-1:0] w_abs_rt;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_step_a;
    logic [DATA_WIDTH-1:0] w_step_b;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0] w_fix_hi;
    logic [DATA_WIDTH-1:0] w_fix_lo;

    assign w_rtype  = (alu_op_i == c_aluop_rtype);
    assign w_mdu_op = w_rtype && (alu_function_i[5:2] == 4'b0110);
    assign w_mf_op  = w_rtype && ((alu_function_i == c_fn_mfhi) ||
                                  (alu_function_i == c_fn_mflo));

    always_comb begin
        alu_operation_o = 4'b1001;
        if (w_rtype) begin
            case (alu_function_i)
                6'b100000: alu_operation_o = 4'b0011;
                6'b100010: alu_operation_o = 4'b0101;
                6'b000000: alu_operation_o = 4'b0010;
                6'b000010: alu_operation_o = 4'b0100;
                6'b100100: alu_operation_o = 4'b0110;
                6'b100111: alu_operation_o = 4'b0111;
                6'b100101: alu_operation_o = 4'b0001;
                6'b011000, 6'b011001, 6'b011010, 6'b011011,
                6'b010000, 6'b010010: alu_operation_o = 4'b1000;
                default:   alu_operation_o = 4'b1001;
            endcase
        end else begin
            case (alu_op_i)
                c_aluop_andi: alu_operation_o = 4'b0110;
                c_aluop_addi: alu_operation_o = 4'b0011;
                c_aluop_lui:  alu_operation_o = 4'b0000;
                c_aluop_ori:  alu_operation_o = 4'b0001;
                c_aluop_lw:   alu_operation_o = 4'b0011;
                default:      alu_operation_o = 4'b1001;
            endcase
        end
    end

    // funct[0] clear selects the signed variants (MULT, DIV)
    assign w_rs_neg = ~alu_function_i[0] & rs_data_i[DATA_WIDTH-1];
    assign w_rt_neg = ~alu_function_i[0] & rt_data_i[DATA_WIDTH-1];
    assign w_abs_rs = w_rs_neg ? -rs_data_i : rs_data_i;
    assign w_abs_rt = w_rt_neg ? -rt_data_i : rt_data_i;

    always_comb begin
        w_sum   = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : '0);
        w_shift = {r_a, r_b[DATA_WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_is_div) begin
            if (!w_diff[DATA_WIDTH]) begin
                w_step_a = w_diff[DATA_WIDTH-1:0];
                w_step_b = {r_b[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_step_a = w_shift[DATA_WIDTH-1:0];
                w_step_b = {r_b[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_a = w_sum[DATA_WIDTH:1];
            w_step_b = {w_sum[0], r_b[DATA_WIDTH-1:1]};
        end
    end

    // Divide by zero leaves quotient all ones; the remainder negation
    // then restores the original dividend exactly.
    always_comb begin
        w_prod = {r_a, r_b};
        if (r_is_div) begin
            w_fix_lo = (r_neg_q && !r_div_zero) ? -r_b : r_b;
            w_fix_hi = r_neg_r ? -r_a : r_a;
        end else begin
            if (r_neg_q) begin
                w_prod = -{r_a, r_b};
            end
            w_fix_hi = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            w_fix_lo = w_prod[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_m        <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i && w_mdu_op) begin
                        r_state    <= S_BUSY;
                        r_count    <= '0;
                        r_a        <= '0;
                        r_b        <= alu_function_i[1] ? w_abs_rs : w_abs_rt;
                        r_m        <= alu_function_i[1] ? w_abs_rt : w_abs_rs;
                        r_is_div   <= alu_function_i[1];
                        r_neg_q    <= w_rs_neg ^ w_rt_neg;
                        r_neg_r    <= w_rs_neg;
                        r_div_zero <= (rt_data_i == '0);
                    end
                end
                S_BUSY: begin
                    r_a     <= w_step_a;
                    r_b     <= w_step_b;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state != S_IDLE);
    assign stall_o      = valid_i && (w_mdu_op || w_mf_op) && (r_state != S_IDLE);
    assign mdu_sel_o    = w_mf_op && (r_state == S_IDLE);
    assign mdu_result_o = (mdu_sel_o && (alu_function_i == c_fn_mfhi)) ? r_hi : r_lo;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu_control
// Brief    : Directed self-checking bench for alu_mdu_control.
// Revision : 1.0
// ============================================================================
module tb_alu_mdu_control;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] rs, rt;
    logic [3:0]   alu_operation;
    logic         mdu_sel;
    logic [W-1:0] mdu_result;
    logic         stall;
    logic         busy;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mdu_control #(.DATA_WIDTH(W), .ALU_OP_WIDTH(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid),
        .alu_op_i        (alu_op),
        .alu_function_i  (funct),
        .rs_data_i       (rs),
        .rt_data_i       (rt),
        .alu_operation_o (alu_operation),
        .mdu_sel_o       (mdu_sel),
        .mdu_result_o    (mdu_result),
        .stall_o         (stall),
        .busy_o          (busy),
        .hi_o            (hi),
        .lo_o            (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        valid  = v;
        alu_op = op;
        funct  = f;
        rs     = a;
        rt     = b;
    endtask

    task automatic run_mdu(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo);
        int cnt;
        @(posedge clk); #1;
        drive(1'b1, 3'b111, f, a, b);
        @(posedge clk); #1;
        drive(1'b0, 3'b000, 6'd0, '0, '0);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(cnt), 64'd33);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    // {alu_op, funct, expected code}
    logic [12:0] dec_tab [23] = '{
        {3'b111, 6'b100000, 4'b0011}, {3'b111, 6'b100010, 4'b0101},
        {3'b111, 6'b000000, 4'b0010}, {3'b111, 6'b000010, 4'b0100},
        {3'b111, 6'b100100, 4'b0110}, {3'b111, 6'b100111, 4'b0111},
        {3'b111, 6'b100101, 4'b0001}, {3'b111, 6'b011000, 4'b1000},
        {3'b111, 6'b011001, 4'b1000}, {3'b111, 6'b011010, 4'b1000},
        {3'b111, 6'b011011, 4'b1000}, {3'b111, 6'b010000, 4'b1000},
        {3'b111, 6'b010010, 4'b1000}, {3'b010, 6'b000000, 4'b0110},
        {3'b100, 6'b000000, 4'b0011}, {3'b000, 6'b100000, 4'b0000},
        {3'b001, 6'b000000, 4'b0001}, {3'b011, 6'b000000, 4'b0011},
        {3'b111, 6'b101010, 4'b1001}, {3'b100, 6'b101010, 4'b0011},
        {3'b100, 6'b011000, 4'b0011}, {3'b101, 6'b000000, 4'b1001},
        {3'b110, 6'b100000, 4'b1001}
    };

    initial begin
        int cnt;
        logic [12:0] e;

        reset = 1'b1;
        drive(1'b0, 3'b000, 6'd0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst sel", 64'(mdu_sel), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);

        for (int i = 0; i < 23; i++) begin
            e = dec_tab[i];
            drive(1'b0, e[12:10], e[9:4], '0, '0);
            #1;
            check($sformatf("decode %03b/%06b", e[12:10], e[9:4]),
                  64'(alu_operation), 64'(e[3:0]));
        end

        run_mdu("mult", 6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_mdu("multu", 6'b011001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        run_mdu("multu max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mdu("div pos/neg", 6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_mdu("div neg/pos", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_mdu("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_mdu("div by zero", 6'b011010, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF);
        run_mdu("div neg by zero", 6'b011010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_mdu("divu by zero", 6'b011011, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);

        // MULT followed immediately by MFLO
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 6'b011000, 32'd5, 32'd6);
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 6'b010010, '0, '0);
        cnt = 0;
        @(negedge clk);
        while (stall && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("mflo stall_cycles", 64'(cnt), 64'd33);
        check("mflo sel", 64'(mdu_sel), 64'd1);
        check("mflo result", 64'(mdu_result), 64'd30);
        funct = 6'b010000;
        #1;
        check("mfhi result", 64'(mdu_result), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 3'b000, 6'd0, '0, '0);

        // ADD during BUSY, then reset mid-operation
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 6'b011001, 32'd7, 32'd9);
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 6'b100000, 32'd1, 32'd2);
        @(negedge clk);
        check("add busy", 64'(busy), 64'd1);
        check("add stall", 64'(stall), 64'd0);
        check("add code", 64'(alu_operation), 64'd3);
        drive(1'b1, 3'b111, 6'b010000, '0, '0);
        #1;
        check("mfhi busy stall", 64'(stall), 64'd1);
        check("mfhi busy sel", 64'(mdu_sel), 64'd0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst stall", 64'(stall), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post-rst stall", 64'(stall), 64'd0);
        check("post-rst sel", 64'(mdu_sel), 64'd1);
        check("post-rst mfhi", 64'(mdu_result), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 3'b000, 6'd0, '0, '0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("aborted lo", 64'(lo), 64'd0);
        check("aborted busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
